// File: rtl/matrix_wb_seq.sv
// Write-back sequencer: drains a ROWS-word matrix result into data memory one word per cycle,
// with one active job, one pending job, and a stall request raised while the pending slot is full.
module matrix_wb_seq #(
    parameter int XLEN        = 32,
    parameter int ROWS        = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_base_addr,
    input  logic [ROWS*XLEN-1:0] in_data,
    output logic                 dmem_wen,
    input  logic                 dmem_ready,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    output logic                 stall_req,
    output logic                 done
);

    localparam int IW = $clog2(ROWS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic [0:0]           state_reg, state_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [XLEN-1:0]      act_base_reg, act_base_next;
    logic [ROWS*XLEN-1:0] act_data_reg, act_data_next;
    logic                 pend_vld_reg, pend_vld_next;
    logic [XLEN-1:0]      pend_base_reg, pend_base_next;
    logic [ROWS*XLEN-1:0] pend_data_reg, pend_data_next;
    logic                 done_reg, done_next;

    logic            accept;
    logic            retire;
    logic            last_retire;
    logic [XLEN-1:0] row_offset;
    logic [XLEN-1:0] act_rows [ROWS];

    // Handshake depends only on registered state, so no combinational path from in_valid.
    assign in_ready    = !pend_vld_reg;
    assign stall_req   = pend_vld_reg;
    assign accept      = in_valid && !pend_vld_reg;
    assign retire      = (state_reg == ST_WRITE) && dmem_ready;
    assign last_retire = retire && (idx_reg == IW'(ROWS - 1));

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
        assign act_rows[gi] = act_data_reg[gi*XLEN +: XLEN];
    end

    // Address arithmetic is done at XLEN width so it wraps naturally past 2^XLEN.
    assign row_offset = XLEN'(idx_reg) * XLEN'(ADDR_STRIDE);

    assign dmem_wen   = (state_reg == ST_WRITE);
    assign dmem_addr  = dmem_wen ? (act_base_reg + row_offset) : '0;
    assign dmem_wdata = dmem_wen ? act_rows[idx_reg] : '0;
    assign done       = done_reg;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        act_base_next  = act_base_reg;
        act_data_next  = act_data_reg;
        pend_vld_next  = pend_vld_reg;
        pend_base_next = pend_base_reg;
        pend_data_next = pend_data_reg;
        done_next      = last_retire;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    act_base_next = in_base_addr;
                    act_data_next = in_data;
                    idx_next      = '0;
                    state_next    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_retire) begin
                    idx_next = '0;
                    if (pend_vld_reg) begin
                        act_base_next = pend_base_reg;
                        act_data_next = pend_data_reg;
                        pend_vld_next = 1'b0;
                    end else if (accept) begin
                        act_base_next = in_base_addr;
                        act_data_next = in_data;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (retire) begin
                        idx_next = idx_reg + 1'b1;
                    end
                    if (accept) begin
                        pend_base_next = in_base_addr;
                        pend_data_next = in_data;
                        pend_vld_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            act_base_reg  <= '0;
            act_data_reg  <= '0;
            pend_vld_reg  <= 1'b0;
            pend_base_reg <= '0;
            pend_data_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            act_base_reg  <= act_base_next;
            act_data_reg  <= act_data_next;
            pend_vld_reg  <= pend_vld_next;
            pend_base_reg <= pend_base_next;
            pend_data_reg <= pend_data_next;
            done_reg      <= done_next;
        end
    end

endmodule
